// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;

    localparam int unsigned N    = 4;
    localparam int unsigned SELW = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N-1:0] onehot(input logic [SELW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after start, wrapping 3->0.
module rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] start,
    output logic            any,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = start;
        cand = start;
        for (int unsigned i = 0; i < N; i++) begin
            // 2-bit add wraps naturally, giving the circular search order
            cand = start + SELW'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with hold-until-release ownership.
// Optional forced release after MAX_HOLD cycles when MUX4_ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    done,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be in 1..255");
    end

    arb_state_e      state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            busy_q, busy_d;

    logic [N-1:0]    pick_req;
    logic [SELW-1:0] pick_start;
    logic            pick_any;
    logic [SELW-1:0] pick_idx;

    logic            owner_drop;
    logic            owner_rel;
    logic            forced;
    logic            new_grant;

    // One picker serves both IDLE arbitration and the release hand-off
    always_comb begin
        pick_req   = req;
        pick_start = ptr_q;
        if (state_q == GRANT) begin
            pick_req   = req & ~onehot(sel_q);
            pick_start = sel_q + SELW'(1);
        end
    end

    rr_pick u_pick (
        .req   (pick_req),
        .start (pick_start),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    assign owner_drop = done[sel_q] | ~req[sel_q];
    assign owner_rel  = (state_q == GRANT) && (owner_drop || forced);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        new_grant = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (owner_rel) begin
                    ptr_d = sel_q + SELW'(1);
                    if (pick_any) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (new_grant) begin
            state_d = GRANT;
            gnt_d   = onehot(pick_idx);
            sel_d   = pick_idx;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    // Forced release only fires when the owner has not already let go this edge
    assign forced = (state_q == GRANT) && !owner_drop && (hold_q == HOLD_LAST);

    always_comb begin
        hold_d    = hold_q;
        timeout_d = forced;
        if (new_grant) begin
            hold_d = '0;
        end else if (state_q == GRANT) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign forced  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter; timeout checks follow MUX4_ARB_TIMEOUT_EN.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int unsigned n_checks;
    int unsigned n_errors;

    mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                             input logic e_busy, input logic e_to);
        check_eq({tag, ".gnt"}, 8'(gnt), 8'(e_gnt));
        check_eq({tag, ".sel"}, 8'(sel), 8'(e_sel));
        check_eq({tag, ".busy"}, 8'(busy), 8'(e_busy));
        check_eq({tag, ".timeout"}, 8'(timeout), 8'(e_to));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 4'b0000;

        // Reset held across edges with requests pending
        tick();
        check_out("rst_a", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_out("rst_b", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_out("first_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        check_out("drop_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single request, release by done; ptr then points at 3
        req = 4'b0100;
        tick();
        check_out("single", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 4'b0100;
        tick();
        check_out("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
        done = 4'b0000;
        req  = 4'b1111;
        tick();
        check_out("ptr_3", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Rotation, back-to-back
        done = 4'b1000;
        tick();
        check_out("rot0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 4'b0001;
        tick();
        check_out("rot1", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 4'b0010;
        tick();
        check_out("rot2", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 4'b0100;
        tick();
        check_out("rot3", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 4'b1000;
        tick();
        check_out("rot4", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Non-owner done ignored; request drop hands off to 3
        done = 4'b0001;
        tick();
        check_out("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 4'b1000;
        tick();
        check_out("ign_done", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 4'b0000;
        req  = 4'b1001;
        tick();
        check_out("req_drop", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Async reset mid-grant
        req = 4'b0100;
        tick();
        check_out("pre_arst", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("arst", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0110;
        tick();
        check_out("arst_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_out("post_arst", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Release and new request on the same edge
        done = 4'b0010;
        req  = 4'b1010;
        tick();
        check_out("simul", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 4'b0000;
        req  = 4'b0000;
        tick();
        check_out("idle2", 4'b0000, 2'd3, 1'b0, 1'b0);

        // Long hold: owner 0 never releases
        req = 4'b0011;
        tick();
        check_out("hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_out("hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
`ifdef MUX4_ARB_TIMEOUT_EN
        check_out("forced", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick();
        check_out("after_to", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        check_out("no_to_a", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_out("no_to_b", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
